// File: rtl/huffman_pkg.sv
// huffman_pkg: shared constants for the Huffman encoder/decoder pair.
// Holds the gray-level symbol codes, the default codeword length and the
// decoder FSM state encoding.
package huffman_pkg;

  localparam int NUM_SYMS     = 6;
  localparam int MAX_CODE_LEN = 8;

  localparam logic [7:0] A1 = 8'd1;
  localparam logic [7:0] A2 = 8'd2;
  localparam logic [7:0] A3 = 8'd3;
  localparam logic [7:0] A4 = 8'd4;
  localparam logic [7:0] A5 = 8'd5;
  localparam logic [7:0] A6 = 8'd6;

  // Table entry i decodes to SYM_CODE[i]
  localparam logic [7:0] SYM_CODE [NUM_SYMS] = '{A1, A2, A3, A4, A5, A6};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DECODE = 2'd2
  } huff_state_e;

endpackage

// File: rtl/huffman_match_unit.sv
// huffman_match_unit: compares the accumulated bits against one table entry.
// An entry matches only when its mask length equals the number of bits
// gathered so far and the masked bits equal its codeword.
module huffman_match_unit #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic [MAX_LEN-1:0] acc_next,
  input  logic [LEN_W-1:0]   len_next,
  input  logic [MAX_LEN-1:0] HC,
  input  logic [MAX_LEN-1:0] M,
  input  logic               entry_valid,
  output logic               match
);

  localparam logic [MAX_LEN:0] ONE_W = {{MAX_LEN{1'b0}}, 1'b1};

  logic [MAX_LEN:0] lenMask;

  // Build the low-ones mask for the current length one bit wider so a
  // full MAX_LEN-bit codeword does not overflow, then compare.
  always_comb begin
    lenMask = (ONE_W << len_next) - ONE_W;
    match   = entry_valid && (lenMask == {1'b0, M}) && ((acc_next & M) == HC);
  end

endmodule

// File: rtl/huffman_decoder.sv
// huffman_decoder: turns a serial Huffman bitstream back into symbols 1..6
// using a codeword/mask table latched on code_valid.
// Optional feature: define HUFFMAN_DEC_STATS_EN to add the dec_count and
// err_count statistics outputs.
module huffman_decoder
  import huffman_pkg::*;
#(
  parameter int MAX_LEN = MAX_CODE_LEN,
  parameter int SYM_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               code_valid,
  input  logic [MAX_LEN-1:0] HC1,
  input  logic [MAX_LEN-1:0] HC2,
  input  logic [MAX_LEN-1:0] HC3,
  input  logic [MAX_LEN-1:0] HC4,
  input  logic [MAX_LEN-1:0] HC5,
  input  logic [MAX_LEN-1:0] HC6,
  input  logic [MAX_LEN-1:0] M1,
  input  logic [MAX_LEN-1:0] M2,
  input  logic [MAX_LEN-1:0] M3,
  input  logic [MAX_LEN-1:0] M4,
  input  logic [MAX_LEN-1:0] M5,
  input  logic [MAX_LEN-1:0] M6,
  input  logic               bit_valid,
  input  logic               bit_in,
  output logic               sym_valid,
  output logic [SYM_W-1:0]   sym_data,
  output logic               err,
  output logic               ready
`ifdef HUFFMAN_DEC_STATS_EN
  ,
  output logic [15:0]        dec_count,
  output logic [7:0]         err_count
`endif
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [MAX_LEN-1:0] ONE_M = {{(MAX_LEN-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]   ONE_L = {{(LEN_W-1){1'b0}}, 1'b1};

  huff_state_e         state_q;
  logic [MAX_LEN-1:0]  hc_q [NUM_SYMS];
  logic [MAX_LEN-1:0]  m_q  [NUM_SYMS];
  logic [MAX_LEN-1:0]  hcIn [NUM_SYMS];
  logic [MAX_LEN-1:0]  mIn  [NUM_SYMS];
  logic [NUM_SYMS-1:0] entryValid_q;
  logic [NUM_SYMS-1:0] maskOk;
  logic [NUM_SYMS-1:0] match;
  // The accumulator is cleared whenever MAX_LEN bits are gathered, so the
  // bit that would shift out of a full-width register is never needed.
  logic [MAX_LEN-2:0]  acc_q;
  logic [MAX_LEN-1:0]  acc_d;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    len_d;
  logic                anyMatch;
  logic [SYM_W-1:0]    matchSym;
  logic                symValid_q;
  logic [SYM_W-1:0]    symData_q;
  logic                err_q;
  logic                ready_q;
`ifdef HUFFMAN_DEC_STATS_EN
  logic [15:0]         decCount_q;
  logic [7:0]          errCount_q;
`endif

  // Gather the flat table ports into arrays and form the shifted bit history
  always_comb begin
    hcIn[0] = HC1; hcIn[1] = HC2; hcIn[2] = HC3;
    hcIn[3] = HC4; hcIn[4] = HC5; hcIn[5] = HC6;
    mIn[0]  = M1;  mIn[1]  = M2;  mIn[2]  = M3;
    mIn[3]  = M4;  mIn[4]  = M5;  mIn[5]  = M6;
    acc_d   = {acc_q, bit_in};
    len_d   = len_q + ONE_L;
  end

  // An entry is usable only if its mask is nonzero and all-low-ones (2^k-1)
  always_comb begin
    maskOk = '0;
    for (int i = 0; i < NUM_SYMS; i++) begin
      maskOk[i] = (m_q[i] != '0) && ((m_q[i] & (m_q[i] + ONE_M)) == '0);
    end
  end

  for (genvar g = 0; g < NUM_SYMS; g++) begin : gMatch
    huffman_match_unit #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
    ) uMatch (
      .acc_next    (acc_d),
      .len_next    (len_d),
      .HC          (hc_q[g]),
      .M           (m_q[g]),
      .entry_valid (entryValid_q[g]),
      .match       (match[g])
    );
  end

  // Lowest-index match wins when a non-prefix-free table gives several hits
  always_comb begin
    anyMatch = 1'b0;
    matchSym = '0;
    for (int i = NUM_SYMS - 1; i >= 0; i--) begin
      if (match[i]) begin
        anyMatch = 1'b1;
        matchSym = SYM_W'(SYM_CODE[i]);
      end
    end
  end

  // Control FSM with table, accumulator and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      entryValid_q <= '0;
      acc_q        <= '0;
      len_q        <= '0;
      symValid_q   <= 1'b0;
      symData_q    <= '0;
      err_q        <= 1'b0;
      ready_q      <= 1'b0;
      for (int i = 0; i < NUM_SYMS; i++) begin
        hc_q[i] <= '0;
        m_q[i]  <= '0;
      end
`ifdef HUFFMAN_DEC_STATS_EN
      decCount_q   <= '0;
      errCount_q   <= '0;
`endif
    end else begin
      symValid_q <= 1'b0;
      err_q      <= 1'b0;
      if (code_valid) begin
        for (int i = 0; i < NUM_SYMS; i++) begin
          hc_q[i] <= hcIn[i];
          m_q[i]  <= mIn[i];
        end
        entryValid_q <= '0;
        acc_q        <= '0;
        len_q        <= '0;
        ready_q      <= 1'b0;
        state_q      <= LOAD;
`ifdef HUFFMAN_DEC_STATS_EN
        decCount_q   <= '0;
        errCount_q   <= '0;
`endif
      end else begin
        case (state_q)
          IDLE: ;
          LOAD: begin
            entryValid_q <= maskOk;
            ready_q      <= 1'b1;
            state_q      <= DECODE;
          end
          DECODE: begin
            if (bit_valid) begin
              if (anyMatch) begin
                symValid_q <= 1'b1;
                symData_q  <= matchSym;
                acc_q      <= '0;
                len_q      <= '0;
`ifdef HUFFMAN_DEC_STATS_EN
                decCount_q <= decCount_q + 16'd1;
`endif
              end else if (len_d == LEN_W'(MAX_LEN)) begin
                err_q <= 1'b1;
                acc_q <= '0;
                len_q <= '0;
`ifdef HUFFMAN_DEC_STATS_EN
                if (errCount_q != 8'hFF) errCount_q <= errCount_q + 8'd1;
`endif
              end else begin
                acc_q <= acc_d[MAX_LEN-2:0];
                len_q <= len_d;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sym_valid = symValid_q;
  assign sym_data  = symData_q;
  assign err       = err_q;
  assign ready     = ready_q;
`ifdef HUFFMAN_DEC_STATS_EN
  assign dec_count = decCount_q;
  assign err_count = errCount_q;
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// tb_huffman_decoder: randomized scoreboard bench for huffman_decoder.
// Build with HUFFMAN_DEC_STATS_EN defined to also exercise the counters.
module tb_huffman_decoder;

  localparam int MAX_LEN = 8;
  localparam int SYM_W   = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               code_valid;
  logic               bit_valid;
  logic               bit_in;
  logic [MAX_LEN-1:0] hcPort [6];
  logic [MAX_LEN-1:0] mPort  [6];
  logic               sym_valid;
  logic [SYM_W-1:0]   sym_data;
  logic               err;
  logic               ready;
`ifdef HUFFMAN_DEC_STATS_EN
  logic [15:0]        dec_count;
  logic [7:0]         err_count;
`endif

  huffman_decoder #(.MAX_LEN(MAX_LEN), .SYM_W(SYM_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .HC1        (hcPort[0]),
    .HC2        (hcPort[1]),
    .HC3        (hcPort[2]),
    .HC4        (hcPort[3]),
    .HC5        (hcPort[4]),
    .HC6        (hcPort[5]),
    .M1         (mPort[0]),
    .M2         (mPort[1]),
    .M3         (mPort[2]),
    .M4         (mPort[3]),
    .M5         (mPort[4]),
    .M6         (mPort[5]),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .sym_valid  (sym_valid),
    .sym_data   (sym_data),
    .err        (err),
    .ready      (ready)
`ifdef HUFFMAN_DEC_STATS_EN
    ,
    .dec_count  (dec_count),
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit isErr;
    int sym;
    int due;
  } exp_t;

  exp_t expQ[$];
  int   tests = 0;
  int   fails = 0;
  int   edgeCount = 0;

  // Reference model: the table as loaded, plus the bits gathered so far
  logic [7:0] tabHC [6];
  logic [7:0] tabM  [6];
  bit         modelReady = 0;
  int         accLen = 0;
  int         accVal = 0;
  int         expDec = 0;
  int         expErr = 0;

  always @(posedge clk) edgeCount++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edgeCount);
    end
  endtask

  // A mask is a valid entry when it is 2^L-1 for some code length L >= 1
  function automatic bit entryUsable(input logic [7:0] m);
    int n;
    n = $countones(m);
    return (n > 0) && (int'(m) == ((1 << n) - 1));
  endfunction

  // Feed one accepted bit to the model and queue any expected output
  task automatic modelBit(input bit b);
    accVal = accVal * 2 + int'(b);
    accLen++;
    for (int i = 0; i < 6; i++) begin
      if (entryUsable(tabM[i]) && accLen == $countones(tabM[i]) && accVal == int'(tabHC[i])) begin
        expQ.push_back('{isErr: 1'b0, sym: i + 1, due: edgeCount + 1});
        expDec++;
        accLen = 0;
        accVal = 0;
        return;
      end
    end
    if (accLen == MAX_LEN) begin
      expQ.push_back('{isErr: 1'b1, sym: 0, due: edgeCount + 1});
      if (expErr < 255) expErr++;
      accLen = 0;
      accVal = 0;
    end
  endtask

  // Drive one cycle of bit input
  task automatic applyStimulus(input bit v, input bit b);
    @(negedge clk);
    code_valid = 1'b0;
    bit_valid  = v;
    bit_in     = b;
    if (v && modelReady) modelBit(b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  task automatic checkStats();
`ifdef HUFFMAN_DEC_STATS_EN
    checkOutput("dec_count", int'(dec_count), expDec % 65536);
    checkOutput("err_count", int'(err_count), expErr);
`endif
  endtask

  // Pulse code_valid with a bit alongside (dropped), a bit during LOAD
  // (ignored), then scramble the ports to show the table was latched
  task automatic loadTable();
    @(negedge clk);
    code_valid = 1'b1;
    bit_valid  = 1'b1;
    bit_in     = 1'($urandom_range(0, 1));
    for (int i = 0; i < 6; i++) begin
      hcPort[i] = tabHC[i];
      mPort[i]  = tabM[i];
    end
    modelReady = 0;
    accLen = 0;
    accVal = 0;
    expDec = 0;
    expErr = 0;
    @(negedge clk);
    code_valid = 1'b0;
    bit_valid  = 1'b1;
    bit_in     = 1'($urandom_range(0, 1));
    for (int i = 0; i < 6; i++) begin
      hcPort[i] = 8'($urandom_range(0, 255));
      mPort[i]  = 8'($urandom_range(0, 255));
    end
    checkOutput("readyInLoad", int'(ready), 0);
    checkStats();
    @(negedge clk);
    bit_valid = 1'b0;
    checkOutput("readyInDecode", int'(ready), 1);
    modelReady = 1;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    modelReady = 0;
    accLen = 0;
    accVal = 0;
    expDec = 0;
    expErr = 0;
    @(negedge clk);
    checkOutput("rstSymValid", int'(sym_valid), 0);
    checkOutput("rstSymData", int'(sym_data), 0);
    checkOutput("rstErr", int'(err), 0);
    checkOutput("rstReady", int'(ready), 0);
    checkStats();
    reset = 1'b0;
  endtask

  task automatic setStdTable(input bit m6Invalid);
    tabHC = '{8'b0, 8'b10, 8'b110, 8'b1110, 8'b11110, 8'b11111};
    tabM  = '{8'd1, 8'd3, 8'd7, 8'd15, 8'd31, 8'd31};
    if (m6Invalid) tabM[5] = 8'd0;
  endtask

  // Random tables mix valid lengths, zero masks, non-contiguous masks and
  // codewords with bits outside their mask
  task automatic setRandomTable();
    for (int i = 0; i < 6; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) tabM[i] = 8'd0;
      else if (r == 9) tabM[i] = 8'h05;
      else tabM[i] = 8'((1 << r) - 1);
      if ($urandom_range(0, 7) == 0) tabHC[i] = 8'($urandom_range(0, 255));
      else tabHC[i] = 8'($urandom_range(0, 255)) & tabM[i];
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents an output
  always @(negedge clk) begin
    if (expQ.size() > 0 && expQ[0].due < edgeCount) begin
      tests++;
      fails++;
      $display("[TB] FAIL missingOutput: got nothing, expected %s sym %0d at edge %0d",
               expQ[0].isErr ? "err" : "sym_valid", expQ[0].sym, expQ[0].due);
      void'(expQ.pop_front());
    end
    if (sym_valid || err) begin
      if (expQ.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpectedOutput: got sym_valid=%0b err=%0b sym=%0d, expected none (edge %0d)",
                 sym_valid, err, sym_data, edgeCount);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("outKind", int'({sym_valid, err}), e.isErr ? 1 : 2);
        if (!e.isErr) checkOutput("symData", int'(sym_data), e.sym);
        checkOutput("latency", edgeCount, e.due);
      end
    end
  end

  initial begin
    reset      = 1'b1;
    code_valid = 1'b0;
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
    for (int i = 0; i < 6; i++) begin
      hcPort[i] = '0;
      mPort[i]  = '0;
    end
    setStdTable(1'b0);
    doReset();

    // Bits before any table is loaded are ignored
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);

    // Back-to-back codewords 0 | 10 | 110
    loadTable();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    idle(2);

    // Gaps inside a codeword hold the partial bits
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    idle(3);
    applyStimulus(1'b1, 1'b0);
    idle(2);
    checkStats();

    // Invalid sixth entry: eight ones overflow into err, then a 0 decodes
    setStdTable(1'b1);
    loadTable();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    idle(2);
    checkStats();

    // Reset mid-codeword discards the partial bits and the table
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
    idle(1);
    doReset();
    applyStimulus(1'b1, 1'b0);
    setStdTable(1'b0);
    loadTable();
    applyStimulus(1'b1, 1'b0);
    idle(2);

    // Random bitstreams over the standard table and random tables
    for (int t = 0; t < 8; t++) begin
      if (t == 0) setStdTable(1'b0);
      else setRandomTable();
      loadTable();
      for (int i = 0; i < 250; i++)
        applyStimulus(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)));
      idle(2);
      checkStats();
    end

    // All entries invalid: every eighth bit errors, enough to saturate err_count
    tabM = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    loadTable();
    for (int i = 0; i < 300 * MAX_LEN; i++) applyStimulus(1'b1, 1'($urandom_range(0, 1)));
    idle(2);
    checkStats();

    // Reload clears the counters (checked inside loadTable)
    setStdTable(1'b0);
    loadTable();
    idle(2);

    checkOutput("queueDrained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
